// File: rtl/mux_stream_arb.sv
// Registered N:1 stream multiplexer with valid/ready handshakes.
// The channel comes from an external select (MODE 0) or a round-robin arbiter (MODE 1).
module mux_stream_arb #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MODE     = 0,
  localparam int unsigned SelW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SelW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SelW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SelW-1:0]    out_chan_q, out_chan_d;
  logic [SelW-1:0]    rr_ptr_q, rr_ptr_d;

  logic               load_en;
  logic               gnt_valid;
  logic [SelW-1:0]    gnt;
  logic               xfer;
  int unsigned        cand;

  assign out_valid = (state_q == StFull);
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign load_en   = !out_valid || out_ready;

  // Comparing against loop indices keeps out-of-range selects from ever reading past in_valid.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    cand      = 0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (!gnt_valid && (32'(sel) == i) && in_valid[i]) begin
          gnt_valid = 1'b1;
          gnt       = SelW'(i);
        end
      end
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        cand = 32'(rr_ptr_q) + k;
        if (cand >= CHANNELS) begin
          cand = cand - CHANNELS;
        end
        if (!gnt_valid && in_valid[SelW'(cand)]) begin
          gnt_valid = 1'b1;
          gnt       = SelW'(cand);
        end
      end
    end
  end

  assign xfer     = !rst && load_en && gnt_valid;
  assign in_ready = xfer ? (CHANNELS'(1) << gnt) : '0;

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    rr_ptr_d   = rr_ptr_q;
    if (xfer) begin
      state_d    = StFull;
      out_data_d = in_data[32'(gnt) * WIDTH +: WIDTH];
      out_chan_d = gnt;
      if (MODE != 0) begin
        rr_ptr_d = (32'(gnt) == CHANNELS - 1) ? '0 : gnt + 1'b1;
      end
    end else if (out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      out_data_q <= '0;
      out_chan_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_mux_stream_arb.sv
// Bench for mux_stream_arb: select-mode, round-robin and 3-channel instances,
// with per-instance scoreboards checked whenever an output word is accepted.
module tb_mux_stream_arb;

  typedef struct {
    logic [3:0]  chan;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] valid;
    logic [3:0] exp_ready;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [127:0] d0_in_data, d1_in_data;
  logic [3:0]   d0_in_valid, d1_in_valid, d0_in_ready, d1_in_ready;
  logic [1:0]   d0_sel, d1_sel, d0_out_chan, d1_out_chan;
  logic [31:0]  d0_out_data, d1_out_data;
  logic         d0_out_valid, d1_out_valid, d0_out_ready, d1_out_ready;

  logic [23:0]  d2_in_data;
  logic [2:0]   d2_in_valid, d2_in_ready;
  logic [1:0]   d2_sel, d2_out_chan;
  logic [7:0]   d2_out_data;
  logic         d2_out_valid, d2_out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q0[$];
  exp_t q1[$];

  mux_stream_arb #(.WIDTH(32), .CHANNELS(4), .MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(d0_in_data), .in_valid(d0_in_valid),
    .in_ready(d0_in_ready), .sel(d0_sel), .out_data(d0_out_data), .out_chan(d0_out_chan),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready)
  );

  mux_stream_arb #(.WIDTH(32), .CHANNELS(4), .MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(d1_in_data), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .sel(d1_sel), .out_data(d1_out_data), .out_chan(d1_out_chan),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready)
  );

  mux_stream_arb #(.WIDTH(8), .CHANNELS(3), .MODE(0)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(d2_in_data), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .sel(d2_sel), .out_data(d2_out_data), .out_chan(d2_out_chan),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs change 1 time unit after posedge, so the negedge sees what the next edge will use.
  always @(negedge clk) begin
    if (!rst && d0_out_valid && d0_out_ready) begin
      if (q0.size() == 0) begin
        check("d0_unexpected_word", 64'(d0_out_data), 64'hdead_0000);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("d0_sb_chan", 64'(d0_out_chan), 64'(e.chan));
        check("d0_sb_data", 64'(d0_out_data), 64'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && d1_out_valid && d1_out_ready) begin
      if (q1.size() == 0) begin
        check("d1_unexpected_word", 64'(d1_out_data), 64'hdead_0001);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("d1_sb_chan", 64'(d1_out_chan), 64'(e.chan));
        check("d1_sb_data", 64'(d1_out_data), 64'(e.data));
      end
    end
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{sel: 2'd0, valid: 4'b0001, exp_ready: 4'b0001};
    vecs[1] = '{sel: 2'd1, valid: 4'b0001, exp_ready: 4'b0000};
    vecs[2] = '{sel: 2'd3, valid: 4'b1000, exp_ready: 4'b1000};
    vecs[3] = '{sel: 2'd3, valid: 4'b0111, exp_ready: 4'b0000};
    vecs[4] = '{sel: 2'd2, valid: 4'b1111, exp_ready: 4'b0100};
    vecs[5] = '{sel: 2'd1, valid: 4'b0010, exp_ready: 4'b0010};
    vecs[6] = '{sel: 2'd0, valid: 4'b1110, exp_ready: 4'b0000};
    vecs[7] = '{sel: 2'd3, valid: 4'b1111, exp_ready: 4'b1000};

    rst = 1'b1;
    d0_in_data = '0; d1_in_data = '0; d2_in_data = '0;
    d0_in_valid = 4'hf; d1_in_valid = 4'hf; d2_in_valid = 3'b111;
    d0_sel = '0; d1_sel = '0; d2_sel = '0;
    d0_out_ready = 1'b0; d1_out_ready = 1'b0; d2_out_ready = 1'b0;

    // Reset with every channel valid
    tick();
    tick();
    check("rst_d0_in_ready", 64'(d0_in_ready), 64'h0);
    check("rst_d1_in_ready", 64'(d1_in_ready), 64'h0);
    check("rst_d0_out_valid", 64'(d0_out_valid), 64'h0);
    check("rst_d0_out_data", 64'(d0_out_data), 64'h0);
    check("rst_d0_out_chan", 64'(d0_out_chan), 64'h0);
    check("rst_d1_out_valid", 64'(d1_out_valid), 64'h0);
    rst = 1'b0;
    d0_in_valid = '0; d1_in_valid = '0; d2_in_valid = '0;
    tick();
    check("idle_d0_out_valid", 64'(d0_out_valid), 64'h0);
    check("idle_d1_out_valid", 64'(d1_out_valid), 64'h0);

    // Out-of-range select on a 3-channel instance gives no grant
    d2_in_data = 24'h33_22_11;
    d2_in_valid = 3'b111; d2_sel = 2'd3; d2_out_ready = 1'b1;
    #1;
    check("oor_in_ready", 64'(d2_in_ready), 64'h0);
    tick();
    check("oor_out_valid", 64'(d2_out_valid), 64'h0);
    d2_sel = 2'd2;
    #1;
    check("d2_sel2_in_ready", 64'(d2_in_ready), 64'h4);
    tick();
    d2_in_valid = '0;
    check("d2_sel2_out_valid", 64'(d2_out_valid), 64'h1);
    check("d2_sel2_out_data", 64'(d2_out_data), 64'h33);

    // Mode 0 select
    d0_sel = 2'd2; d0_in_valid = 4'b0100; d0_in_data[64 +: 32] = 32'h7575_7575;
    d0_out_ready = 1'b1;
    #1;
    check("sel2_in_ready", 64'(d0_in_ready), 64'h4);
    q0.push_back('{chan: 4'd2, data: 32'h7575_7575});
    tick();
    check("sel2_out_valid", 64'(d0_out_valid), 64'h1);
    check("sel2_out_data", 64'(d0_out_data), 64'h7575_7575);
    check("sel2_out_chan", 64'(d0_out_chan), 64'h2);
    d0_sel = 2'd1; d0_in_valid = 4'b0000;
    #1;
    check("sel1_novalid_in_ready", 64'(d0_in_ready), 64'h0);
    tick();
    check("sel1_novalid_out_valid", 64'(d0_out_valid), 64'h0);

    // Backpressure holds the word and blocks new grants
    d0_sel = 2'd0; d0_in_valid = 4'b0001; d0_in_data[0 +: 32] = 32'hcdcd_cdcd;
    d0_out_ready = 1'b0;
    q0.push_back('{chan: 4'd0, data: 32'hcdcd_cdcd});
    tick();
    d0_in_data[0 +: 32] = 32'h0005_7575;
    for (int c = 0; c < 3; c++) begin
      check("bp_in_ready", 64'(d0_in_ready), 64'h0);
      check("bp_out_data", 64'(d0_out_data), 64'hcdcd_cdcd);
      check("bp_out_valid", 64'(d0_out_valid), 64'h1);
      tick();
    end
    d0_out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(d0_in_ready), 64'h1);
    q0.push_back('{chan: 4'd0, data: 32'h0005_7575});
    tick();
    check("bp_next_out_valid", 64'(d0_out_valid), 64'h1);
    check("bp_next_out_data", 64'(d0_out_data), 64'h0005_7575);
    d0_in_valid = '0;
    tick();

    // Table of select vectors, output always ready
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 4; i++) d0_in_data[i*32 +: 32] = 32'ha000_0000 + 32'(v * 16 + i);
      d0_sel = vecs[v].sel; d0_in_valid = vecs[v].valid;
      #1;
      check("tbl_in_ready", 64'(d0_in_ready), 64'(vecs[v].exp_ready));
      if (vecs[v].exp_ready != 4'b0000)
        q0.push_back('{chan: 4'(vecs[v].sel),
                       data: 32'ha000_0000 + 32'(v * 16) + 32'(vecs[v].sel)});
      tick();
    end
    d0_in_valid = '0;
    tick();
    tick();
    check("q0_drained", 64'(q0.size()), 64'h0);

    // Mode 1 fairness with all channels valid
    for (int i = 0; i < 4; i++) d1_in_data[i*32 +: 32] = 32'h10 + 32'(i);
    d1_in_valid = 4'hf; d1_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) q1.push_back('{chan: 4'(k % 4), data: 32'h10 + 32'(k % 4)});
    for (int k = 0; k < 6; k++) tick();
    d1_in_valid = '0;
    tick();

    // Wrap and skip: pointer now at 2, one grant on channel 2 moves it to 3
    d1_in_data[64 +: 32] = 32'h22; d1_in_data[0 +: 32] = 32'h20; d1_in_data[96 +: 32] = 32'h33;
    d1_in_valid = 4'b0100;
    q1.push_back('{chan: 4'd2, data: 32'h22});
    tick();
    d1_in_valid = 4'b0101;
    #1;
    check("wrap_in_ready", 64'(d1_in_ready), 64'h1);
    q1.push_back('{chan: 4'd0, data: 32'h20});
    tick();
    check("skip_in_ready", 64'(d1_in_ready), 64'h4);
    q1.push_back('{chan: 4'd2, data: 32'h22});
    tick();
    d1_in_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("only3_in_ready", 64'(d1_in_ready), 64'h8);
      q1.push_back('{chan: 4'd3, data: 32'h33});
      tick();
    end
    d1_in_valid = '0;
    tick();
    tick();
    check("q1_drained", 64'(q1.size()), 64'h0);

    // Reset mid-transfer drops the held word and the pointer
    d1_in_data[32 +: 32] = 32'h44; d1_in_valid = 4'b0010; d1_out_ready = 1'b0;
    tick();
    check("mid_full_out_valid", 64'(d1_out_valid), 64'h1);
    check("mid_full_out_chan", 64'(d1_out_chan), 64'h1);
    rst = 1'b1; d1_in_valid = 4'hf;
    #1;
    check("mid_rst_in_ready", 64'(d1_in_ready), 64'h0);
    tick();
    check("mid_rst_out_valid", 64'(d1_out_valid), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) d1_in_data[i*32 +: 32] = 32'h50 + 32'(i);
    d1_out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(d1_in_ready), 64'h1);
    q1.push_back('{chan: 4'd0, data: 32'h50});
    tick();
    check("post_rst_out_chan", 64'(d1_out_chan), 64'h0);
    d1_in_valid = '0;
    tick();
    tick();
    check("q1_final_drained", 64'(q1.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
